// File: rtl/miner_pkg.sv
// Shared miner types and helpers: hash word layout and the byte swap used by
// the hash/target magnitude compare.
package miner_pkg;

    localparam int unsigned HASH_WORDS = 8;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned HASH_W     = HASH_WORDS * WORD_W;
    localparam int unsigned CNT_W      = 64;

    typedef logic [HASH_WORDS-1:0][WORD_W-1:0] hash_t;

    // Byte 0 of a word sits in bits [7:0] but is its most significant byte.
    function automatic logic [WORD_W-1:0] bswap32(input logic [WORD_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Swap every word of a hash; applying it twice restores the original.
    function automatic hash_t hash_bswap(input hash_t h);
        hash_t r;
        for (int w = 0; w < int'(HASH_WORDS); w++) begin
            r[w] = bswap32(h[w]);
        end
        return r;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Result FIFO with a registered head and registered full/empty flags.
// Pointers carry one extra bit so full and empty are distinguishable.
// The head register keeps its last value while the FIFO is empty.
module result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 320
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] data
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_nxt;
    logic [AW:0]      rd_nxt;
    logic [AW:0]      used_c;
    logic [WIDTH-1:0] data_nxt;
    logic             push_ok;
    logic             pop_ok;

    // A full FIFO still takes a push when the head leaves on the same edge.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign used_c  = wr_ptr - rd_ptr;

    // Next pointers and next head value; clear wins over push and pop.
    always_comb begin
        wr_nxt   = wr_ptr + (AW+1)'(push_ok);
        rd_nxt   = rd_ptr + (AW+1)'(pop_ok);
        data_nxt = data;
        if (pop_ok) begin
            if (used_c >= (AW+1)'(2)) begin
                data_nxt = mem[rd_ptr[AW-1:0] + AW'(1)];
            end else if (push_ok) begin
                data_nxt = wdata;
            end
        end else if (empty && push_ok) begin
            data_nxt = wdata;
        end
        if (clear) begin
            wr_nxt   = '0;
            rd_nxt   = '0;
            data_nxt = data;
        end
    end

    // Pointer, flag and head registers.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            data   <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            data   <= data_nxt;
            empty  <= (wr_nxt == rd_nxt);
            full   <= (wr_nxt[AW] != rd_nxt[AW]) &&
                      (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
        end
    end

    // Storage array; contents need no reset since pointers gate every read.
    always_ff @(posedge Clk) begin
        if (push_ok && !clear) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/hash_checker.sv
// Hash checker: compares each BLAKE3 hash against a difficulty target in a
// two-stage pipeline and queues winners (hash < target) with their nonce.
// FIFO_DEPTH must be a power of two and at least 2.
// Optional: define HASH_CHECKER_CNT_EN to enable the 64-bit hash counter.
module hash_checker
    import miner_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned NONCE_W    = 64
) (
    input  logic               Clk,
    input  logic               Rst_I,
    input  logic               Vld_I,
    input  hash_t              H_I,
    input  logic [NONCE_W-1:0] Nonce_I,
    input  hash_t              Target_I,
    input  logic               Target_Ld_I,
    input  logic               Clear_I,
    output logic               Found_Vld_O,
    input  logic               Found_Rdy_I,
    output logic [NONCE_W-1:0] Found_Nonce_O,
    output hash_t              Found_Hash_O,
    output logic               Drop_O,
    output logic [CNT_W-1:0]   Hash_Cnt_O
);

    localparam int unsigned ENTRY_W = NONCE_W + HASH_W;

    hash_t                 target_q;
    hash_t                 hsw_c;
    hash_t                 tsw_c;
    logic [HASH_WORDS-1:0] lt_c;
    logic [HASH_WORDS-1:0] eq_c;

    logic                  s1_vld;
    logic [HASH_WORDS-1:0] s1_lt;
    logic [HASH_WORDS-1:0] s1_eq;
    hash_t                 s1_hsw;
    logic [NONCE_W-1:0]    s1_nonce;

    logic                  win_c;
    logic                  done_c;

    logic                  s2_vld;
    logic                  s2_win;
    logic [NONCE_W-1:0]    s2_nonce;
    hash_t                 s2_hash;

    logic                  push_c;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    fifo_data;

    // Target register; zero after reset so nothing wins before a load.
    always_ff @(posedge Clk or posedge Rst_I) begin
        if (Rst_I) begin
            target_q <= '0;
        end else if (Target_Ld_I) begin
            target_q <= Target_I;
        end
    end

    // Per-word magnitude flags on byte-swapped words.
    always_comb begin
        hsw_c = hash_bswap(H_I);
        tsw_c = hash_bswap(target_q);
        lt_c  = '0;
        eq_c  = '0;
        for (int w = 0; w < int'(HASH_WORDS); w++) begin
            lt_c[w] = (hsw_c[w] < tsw_c[w]);
            eq_c[w] = (hsw_c[w] == tsw_c[w]);
        end
    end

    // Stage 1: capture flags, swapped hash and nonce with the target in force now.
    always_ff @(posedge Clk or posedge Rst_I) begin
        if (Rst_I) begin
            s1_vld   <= 1'b0;
            s1_lt    <= '0;
            s1_eq    <= '0;
            s1_hsw   <= '0;
            s1_nonce <= '0;
        end else begin
            s1_vld   <= Vld_I & ~Clear_I;
            s1_lt    <= lt_c;
            s1_eq    <= eq_c;
            s1_hsw   <= hsw_c;
            s1_nonce <= Nonce_I;
        end
    end

    // First differing word from word 0 down decides; all-equal is not a win.
    always_comb begin
        win_c  = 1'b0;
        done_c = 1'b0;
        for (int w = 0; w < int'(HASH_WORDS); w++) begin
            if (!done_c && !s1_eq[w]) begin
                win_c  = s1_lt[w];
                done_c = 1'b1;
            end
        end
    end

    // Stage 2: registered win decision with the original-order hash.
    always_ff @(posedge Clk or posedge Rst_I) begin
        if (Rst_I) begin
            s2_vld   <= 1'b0;
            s2_win   <= 1'b0;
            s2_nonce <= '0;
            s2_hash  <= '0;
        end else begin
            s2_vld   <= s1_vld & ~Clear_I;
            s2_win   <= win_c;
            s2_nonce <= s1_nonce;
            s2_hash  <= hash_bswap(s1_hsw);
        end
    end

    assign push_c = s2_vld & s2_win;

    result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .Clk   (Clk),
        .rst   (Rst_I),
        .push  (push_c),
        .pop   (Found_Rdy_I),
        .clear (Clear_I),
        .wdata ({s2_nonce, s2_hash}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .data  (fifo_data)
    );

    assign Found_Vld_O                   = ~fifo_empty;
    assign {Found_Nonce_O, Found_Hash_O} = fifo_data;

    // Sticky loss flag: a winner met a full FIFO with no pop on that edge.
    always_ff @(posedge Clk or posedge Rst_I) begin
        if (Rst_I) begin
            Drop_O <= 1'b0;
        end else if (Clear_I) begin
            Drop_O <= 1'b0;
        end else if (push_c && fifo_full && !Found_Rdy_I) begin
            Drop_O <= 1'b1;
        end
    end

`ifdef HASH_CHECKER_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Free-running count of sampled hashes; unaffected by Clear_I.
    always_ff @(posedge Clk or posedge Rst_I) begin
        if (Rst_I) begin
            cnt_q <= '0;
        end else if (Vld_I) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign Hash_Cnt_O = cnt_q;
`else
    assign Hash_Cnt_O = '0;
`endif

endmodule

// File: doc/hash_checker.md
HASH_CHECKER -- requirements
Module: hash_checker

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, is the result FIFO depth; it SHALL be a power of two and at least 2.
REQ-002 Parameter NONCE_W, default 64, is the nonce tag width.
REQ-003 Clk  in  1  single clock; all flops SHALL be rising-edge.
REQ-004 Rst_I  in  1  reset, asynchronous and active-high.
REQ-005 Vld_I  in  1  H_I and Nonce_I are valid this cycle (driven by HashGen Vld_O).
REQ-006 H_I  in  [7:0][31:0]  BLAKE3 hash from HashGen H_O.
REQ-007 Nonce_I  in  NONCE_W  nonce that produced H_I, presented in the same cycle.
REQ-008 Target_I  in  [7:0][31:0]  difficulty target, in the same byte order as H_I.
REQ-009 Target_Ld_I  in  1  load Target_I into the target register.
REQ-010 Clear_I  in  1  synchronous flush of the pipeline, the FIFO and Drop_O.
REQ-011 Found_Vld_O  out  1  FIFO head is valid.
REQ-012 Found_Rdy_I  in  1  consumer accepts the head when high with Found_Vld_O.
REQ-013 Found_Nonce_O  out  NONCE_W  nonce at the FIFO head.
REQ-014 Found_Hash_O  out  [7:0][31:0]  hash at the FIFO head.
REQ-015 Drop_O  out  1  sticky flag: a winning hash was lost because the FIFO was full.
REQ-016 Hash_Cnt_O  out  64  count of accepted Vld_I (see Configuration).

Function
REQ-017 Compare value: byte k of the hash SHALL be H_I[k/4][8*(k%4)+7 : 8*(k%4)]; byte 0 is the most significant byte of a 256-bit unsigned value. Target_I SHALL be interpreted the same way.
REQ-018 A hash SHALL win if and only if its value is strictly less than the target. Equal is not a win.
REQ-019 Stage 1, on the edge that samples Vld_I: per-word lt/eq flags are registered with the byte-swapped words, Nonce_I, H_I and a valid bit.
REQ-020 Stage 2, on the next edge: the flags are reduced from the most significant word down, and the win/valid result is registered.
REQ-021 A win SHALL be written into the FIFO on the edge after stage 2. For a Vld_I sampled at edge N on an empty FIFO, Found_Vld_O SHALL be high in the cycle after edge N+2.
REQ-022 The pipeline SHALL accept one Vld_I per cycle with no stall and no backpressure on the input.
REQ-023 Target_Ld_I sampled at edge N SHALL apply to every Vld_I sampled at edge N+1 or later. Hashes already in stage 1 use the target captured with them.
REQ-024 A FIFO pop SHALL occur on each edge where Found_Vld_O and Found_Rdy_I are both high.
REQ-025 Full FIFO:
  - a win with no pop SHALL be discarded, and Drop_O SHALL be set;
  - a win with a simultaneous pop SHALL be accepted without loss.
REQ-026 Empty FIFO: Found_Vld_O SHALL be low, and Found_Nonce_O/Found_Hash_O hold their last value.
REQ-027 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, with one extra bit used to distinguish full from empty.
REQ-028 Clear_I SHALL:
  - invalidate both stage valid bits;
  - empty the FIFO;
  - clear Drop_O;
  - leave the target register unchanged.
  Clear_I overrides a simultaneous push or pop.

Reset
REQ-029 Rst_I SHALL asynchronously clear:
  - stage valid bits and FIFO pointers;
  - Found_Vld_O = 0, Drop_O = 0, Hash_Cnt_O = 0;
  - Found_Nonce_O = 0, Found_Hash_O = 0;
  - the target register = all zeros, so no hash can win until a load.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight and queued results, and no Found_Vld_O pulse SHALL follow reset release.

Configuration
REQ-031 HASH_CHECKER_CNT_EN defined: Hash_Cnt_O SHALL increment by 1 per sampled Vld_I and wrap at 2^64. Clear_I does not reset the counter.
REQ-032 HASH_CHECKER_CNT_EN undefined: no counter logic SHALL exist, and Hash_Cnt_O SHALL be tied to 0.

Structure
REQ-033 Package miner_pkg SHALL hold:
  - HASH_WORDS = 8;
  - typedef hash_t (logic [7:0][31:0]);
  - the byte-swap function used by the compare.
REQ-034 The FIFO SHALL be the sub-module result_fifo, with parameters DEPTH and WIDTH = NONCE_W + 256, and ports push, pop, clear, full, empty and data.

Verification
REQ-035 Scenario "reset target": after reset with no load, Vld_I with H_I all zero -> no Found_Vld_O.
REQ-036 Scenario "win": Target byte0 = 0x01, rest 0x00; H_I byte0 = 0x00, rest 0xFF, Nonce_I = 0x5 -> Found_Vld_O high 3 cycles later with Found_Nonce_O = 0x5.
REQ-037 Scenario "equal": H_I equal to Target_I -> no win.
REQ-038 Scenario "overflow": FIFO_DEPTH = 4, Found_Rdy_I = 0, 6 consecutive winning Vld_I (nonces 1..6) -> FIFO holds 1..4 and Drop_O = 1; draining returns 1,2,3,4 in order.
REQ-039 Scenario "full with pop": full FIFO, Found_Rdy_I = 1 with a win arriving in the same cycle -> Drop_O stays 0 and the count stays 4.
REQ-040 Scenario "target switch": Target_Ld_I in the same cycle as Vld_I -> old target used; next-cycle Vld_I -> new target used. Clear_I mid-stream -> FIFO empty next cycle, Drop_O = 0, and Hash_Cnt_O unchanged when HASH_CHECKER_CNT_EN is defined.
